// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the systolic array blocks
package systolic_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width needed to index n items; never narrower than one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 31; k++)
      if ((1 << k) < n) w = k + 1;
    return w;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_skew.sv
// rtl/systolic_feed_ctrl_skew.sv - per-lane delay line, DEPTH word+valid stages
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_vld,
  output logic [DW-1:0] out_data,
  output logic          out_vld
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Lane 0 needs no skew; its input is already a register in the parent.
      assign out_data = in_data;
      assign out_vld  = in_vld;
    end else begin : g_dly
      logic [DW-1:0]    d_q [DEPTH];
      logic [DEPTH-1:0] v_q;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          v_q <= '0;
          for (int j = 0; j < DEPTH; j++) d_q[j] <= '0;
        end else begin
          d_q[0] <= in_data;
          v_q[0] <= in_vld;
          for (int j = 1; j < DEPTH; j++) begin
            d_q[j] <= d_q[j-1];
            v_q[j] <= v_q[j-1];
          end
        end
      end

      assign out_data = d_q[DEPTH-1];
      assign out_vld  = v_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - reads N matrix rows and feeds them diagonally skewed
// into the systolic array, with clear, mode, abort and completion handshakes.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = DW_DEF,
  parameter int FLUSH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode_in,
  output logic                   rd_en,
  output logic [clog2w(N)-1:0]   rd_addr,
  input  logic [N*DW-1:0]        rd_data,
  output logic [N*DW-1:0]        x_out,
  output logic [N-1:0]           x_vld,
  output logic                   operation,
  output logic                   array_clr,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = clog2w(N);
  localparam int CW = clog2w(2 * N + FLUSH + 2);

  state_t          state;
  logic [CW-1:0]   cyc;
  logic            rd_pend;
  logic [N*DW-1:0] cap_data;
  logic            cap_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cyc       <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_pend   <= 1'b0;
      operation <= 1'b0;
      array_clr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      array_clr <= 1'b0;
      done      <= 1'b0;
      rd_pend   <= rd_en && !abort;
      if (abort && state != ST_IDLE) begin
        state   <= ST_IDLE;
        cyc     <= '0;
        rd_en   <= 1'b0;
        rd_addr <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state     <= ST_LOAD;
              cyc       <= '0;
              rd_en     <= 1'b1;
              rd_addr   <= '0;
              array_clr <= 1'b1;
              busy      <= 1'b1;
              operation <= mode_in;
            end
          end
          ST_LOAD: begin
            cyc <= cyc + CW'(1);
            if (cyc == CW'(N - 1)) begin
              state   <= ST_DRAIN;
              rd_en   <= 1'b0;
              rd_addr <= '0;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
          ST_DRAIN: begin
            cyc <= cyc + CW'(1);
            // cyc equals the job cycle number; the last flush cycle is 2N+FLUSH.
            if (cyc == CW'(2 * N + FLUSH)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            cyc   <= '0;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Row data arrives the cycle after the strobe; capture it zeroed when not requested.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      cap_data <= '0;
      cap_vld  <= 1'b0;
    end else begin
      cap_data <= rd_pend ? rd_data : '0;
      cap_vld  <= rd_pend;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay #(.DEPTH(i), .DW(DW)) u_skew (
      .clk      (clk),
      .rst      (rst),
      .clr      (abort),
      .in_data  (cap_data[i*DW +: DW]),
      .in_vld   (cap_vld),
      .out_data (x_out[i*DW +: DW]),
      .out_vld  (x_vld[i])
    );
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - directed bench with a job-cycle model of the feeder
module tb_systolic_feed_ctrl;

  localparam int N      = 4;
  localparam int DW     = 32;
  localparam int FLUSH  = 4;
  localparam int DONE_T = 2 * N + FLUSH + 1;

  logic            clk = 1'b0;
  logic            rst, start, abort, mode_in;
  logic            rd_en;
  logic [1:0]      rd_addr;
  logic [N*DW-1:0] rd_data = '0;
  logic [N*DW-1:0] x_out;
  logic [N-1:0]    x_vld;
  logic            operation, array_clr, busy, done;

  systolic_feed_ctrl #(.N(N), .DW(DW), .FLUSH(FLUSH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mode_in   (mode_in),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .x_out     (x_out),
    .x_vld     (x_vld),
    .operation (operation),
    .array_clr (array_clr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] seed = '0;
  logic chk_en = 1'b0;

  function automatic logic [31:0] gen(input int k, input int i);
    return seed + 32'(16 * k + i);
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Row buffer: returns the requested row one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      rd_data[i*DW +: DW] <= rd_en ? gen(int'(rd_addr), i) : 32'hDEAD_BEEF;
  end

  // Model: t is the job cycle number, -1 when idle.
  int   t = -1;
  logic m_op = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      t = -1; m_op = 1'b0;
    end else if (t >= 0) begin
      if (abort || t == DONE_T) t = -1;
      else t = t + 1;
    end else if (start && !abort) begin
      t = 0; m_op = mode_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N*DW-1:0] ex;
      logic [N-1:0]    ev;
      logic            e_rd;
      logic [1:0]      e_addr;
      ex = '0; ev = '0;
      e_rd   = (t >= 0 && t < N);
      e_addr = e_rd ? 2'(t) : 2'd0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = t - 2 - i;
        if (t >= 0 && k >= 0 && k < N) begin
          ev[i] = 1'b1;
          ex[i*DW +: DW] = gen(k, i);
        end
      end
      chk("ctrl", {rd_en, rd_addr, array_clr, busy, done, operation},
                  {e_rd, e_addr, t == 0, t >= 0, t == DONE_T, m_op});
      chk("data", {x_vld, x_out}, {ev, ex});
    end
  end

  function automatic logic [31:0] lane(input int i);
    return x_out[i*DW +: DW];
  endfunction

  // Pulses start for one cycle; returns at the negedge inside job cycle 0.
  task automatic kick(input logic m);
    @(negedge clk); start = 1'b1; mode_in = m;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode_in = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_state", {busy, rd_en, x_vld, operation, array_clr, done}, '0);
    rst = 1'b0;

    // Single job, neighbouring pivoting, rows 16k+i.
    kick(1'b1);
    for (int c = 0; c <= 16; c++) begin
      if (c == 0) chk("c0_clr_rd", {array_clr, rd_en, rd_addr, operation}, 5'b11001);
      if (c == 3) chk("c3_addr", {rd_en, rd_addr}, 3'b111);
      if (c == 2) chk("lane0_c2", {x_vld[0], lane(0)}, {1'b1, 32'd0});
      if (c == 5) chk("lane0_c5", {x_vld[0], lane(0)}, {1'b1, 32'd48});
      if (c == 5) chk("lane3_c5", {x_vld[3], lane(3)}, {1'b1, 32'd3});
      if (c == 8) chk("lane3_c8", {x_vld[3], lane(3)}, {1'b1, 32'd51});
      if (c == 9) chk("c9_idle_lanes", {x_vld, x_out}, '0);
      if (c == 12) chk("c12_no_done", done, 1'b0);
      if (c == 13) chk("c13_done", {done, busy}, 2'b11);
      if (c == 14) chk("c14_idle", {done, busy}, 2'b00);
      @(negedge clk);
    end

    // Start held high: back-to-back jobs with one idle cycle between.
    seed = 32'd1000;
    @(negedge clk); start = 1'b1; mode_in = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 15; c++) begin
      if (c == 14) chk("hold_gap", busy, 1'b0);
      @(negedge clk);
    end
    chk("hold_restart", {array_clr, busy, operation}, 3'b110);
    start = 1'b0;
    repeat (16) @(negedge clk);

    // Abort mid-job.
    seed = 32'd2000;
    kick(1'b1);
    seen_done = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 6) abort = 1'b1;
      if (c == 7) begin
        abort = 1'b0;
        chk("abort_c7", {busy, rd_en, x_vld, x_out, operation}, {2'b00, 4'b0, 128'd0, 1'b1});
      end
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", seen_done, 1'b0);

    // Start together with abort in IDLE: ignored, operation retained.
    start = 1'b1; abort = 1'b1; mode_in = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {busy, rd_en, operation}, 3'b001);
    @(negedge clk);
    chk("start_abort_idle2", {busy, rd_en}, 2'b00);
    seed = 32'd3000;
    kick(1'b0);
    chk("mode0_job", {busy, operation}, 2'b10);
    repeat (16) @(negedge clk);

    // Reset mid-job with start high.
    kick(1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_midjob", {busy, rd_en, rd_addr, x_vld, x_out, operation, array_clr, done},
                      '0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", {busy, rd_en}, 2'b00);
    kick(1'b1);
    chk("after_rst_job", {busy, array_clr, operation}, 3'b111);
    repeat (16) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 Parameter N, default 4, array dimension: rows per matrix, lanes, boundary cells on the diagonal.
REQ-002 Parameter DW, default 32, data word width, IEEE-754 single.
REQ-003 Parameter FLUSH, default 4, cycles of propagation allowed after the last valid lane word.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  job request, sampled only in IDLE.
REQ-007 abort  in  1  terminate current job.
REQ-008 mode_in  in  1  1 = neighbouring-pivoting, 0 = non-pivoting; sampled with accepted start.
REQ-009 rd_en  out  1  matrix row read strobe to row buffer.
REQ-010 rd_addr  out  clog2(N)  row index being read.
REQ-011 rd_data  in  N*DW  row returned one cycle after rd_en; lane i = bits [i*DW +: DW].
REQ-012 x_out  out  N*DW  skewed words to array column inputs.
REQ-013 x_vld  out  N  per-lane valid.
REQ-014 operation  out  1  mode to all boundary/internal cells.
REQ-015 array_clr  out  1  one-cycle clear pulse ORed into cell resets.
REQ-016 busy  out  1  job in progress.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states IDLE, LOAD, DRAIN, DONE; IDLE->LOAD on start; LOAD->DRAIN after N read cycles; DRAIN->DONE after last valid word plus FLUSH cycles; DONE->IDLE unconditionally.
REQ-019 Cycle 0 = first cycle after start sampled high in IDLE; in cycle 0 state is LOAD, busy=1, array_clr=1.
REQ-020 rd_en=1 with rd_addr=k in cycles k = 0..N-1; rd_en=0 and rd_addr=0 otherwise.
REQ-021 Element (row k, column i) appears on x_out lane i with x_vld[i]=1 in cycle k+2+i exactly.
REQ-022 Lane words with x_vld[i]=0 are zero.
REQ-023 Last valid word in cycle 2N; DRAIN covers cycles 2N+1..2N+FLUSH; done=1 and busy=1 in cycle 2N+FLUSH+1 (DONE); IDLE thereafter.
REQ-024 operation latched from mode_in when start accepted; held constant until next accepted start.
REQ-025 start while not IDLE is ignored, no queuing; start in DONE cycle is ignored.
REQ-026 abort in any non-IDLE state: next cycle IDLE, busy=0, rd_en=0, x_vld=0, all skew registers zero, no done pulse; operation retained.
REQ-027 abort and start together in IDLE: start ignored.
REQ-028 Row counter wraps never: exactly N reads per job regardless of N being power of two.

Reset
REQ-029 rst forces IDLE next edge, overriding start and abort, including mid-job.
REQ-030 Reset values: rd_en=0, rd_addr=0, x_out=0, x_vld=0, operation=0, array_clr=0, busy=0, done=0, all counters and skew registers 0.

Structure
REQ-031 Shared package systolic_pkg holds DW default, FSM state enum, and the clog2 width helper; used by array-level modules.
REQ-032 One sub-module skew_delay (parameter DEPTH, DW data plus valid, synchronous clear) instantiated per lane with DEPTH=i.
REQ-033 All outputs registered; no combinational path from inputs to outputs.

Verification (N=4, FLUSH=4)
REQ-034 Reset then start=1 for one cycle, mode_in=1 -> cycle 0 array_clr=1, rd_en cycles 0-3 addr 0,1,2,3, operation=1, done at cycle 13 only.
REQ-035 rd_data row k lane i = 16k+i -> lane 3 shows 3,19,35,51 in cycles 5-8; lane 0 shows 0,16,32,48 in cycles 2-5; zero elsewhere.
REQ-036 start held high continuously -> second job cycle 0 is cycle 15 (two cycles after done), no overlap.
REQ-037 abort in cycle 6 -> cycle 7 busy=0, x_vld=0000, x_out=0, no done through cycle 20.
REQ-038 rst asserted in cycle 3 with start=1 -> next cycle IDLE, all outputs reset values; no job until start after rst drops.
REQ-039 start and abort together in IDLE -> busy stays 0, rd_en stays 0; mode_in=0 job afterwards -> operation=0.
